// File: rtl/gps_ch_axil_if.sv
// AXI4-Lite bundle between the interconnect and one correlator channel.
interface gps_ch_axil_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gps_ch_axil_regs.sv
// Channel control registers and dump snapshot behind AXI4-Lite.
// GPS_CH_SNAP_LOCK_EN: lock snapshot between DUMP_SEQ and QL reads.
module gps_ch_axil_regs #(
  parameter int ADDR_W  = 12,
  parameter int ACC_W   = 18,
  parameter int PHASE_W = 32
) (
  input  logic               axi_clk,
  input  logic               axi_rstn,
  gps_ch_axil_if.slave       s_axi,
  input  logic               dump_in,
  input  logic [ACC_W-1:0]   ie_in,
  input  logic [ACC_W-1:0]   qe_in,
  input  logic [ACC_W-1:0]   ip_in,
  input  logic [ACC_W-1:0]   qp_in,
  input  logic [ACC_W-1:0]   il_in,
  input  logic [ACC_W-1:0]   ql_in,
  output logic [31:0]        tic_cycles,
  output logic               tic_en,
  output logic [5:0]         prn,
  output logic               ch_en,
  output logic [PHASE_W-1:0] carr_incr,
  output logic [PHASE_W-1:0] code_incr,
  output logic [10:0]        slew_hc,
  output logic               slew_req
);

  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;

  localparam logic [ADDR_W-1:0] A_TIC  = ADDR_W'(12'h008);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(12'h00C);
  localparam logic [ADDR_W-1:0] A_PRN  = ADDR_W'(12'h020);
  localparam logic [ADDR_W-1:0] A_CARR = ADDR_W'(12'h024);
  localparam logic [ADDR_W-1:0] A_CODE = ADDR_W'(12'h028);
  localparam logic [ADDR_W-1:0] A_SLEW = ADDR_W'(12'h02C);
  localparam logic [ADDR_W-1:0] A_SREQ = ADDR_W'(12'h030);
  localparam logic [ADDR_W-1:0] A_SEQ  = ADDR_W'(12'h100);
  localparam logic [ADDR_W-1:0] A_IE   = ADDR_W'(12'h104);
  localparam logic [ADDR_W-1:0] A_QE   = ADDR_W'(12'h108);
  localparam logic [ADDR_W-1:0] A_IP   = ADDR_W'(12'h10C);
  localparam logic [ADDR_W-1:0] A_QP   = ADDR_W'(12'h110);
  localparam logic [ADDR_W-1:0] A_IL   = ADDR_W'(12'h114);
  localparam logic [ADDR_W-1:0] A_QL   = ADDR_W'(12'h118);
`ifdef GPS_CH_SNAP_LOCK_EN
  localparam logic [ADDR_W-1:0] A_LOST = ADDR_W'(12'h11C);
`endif

  typedef enum logic [0:0] {
    WS_ADDR,
    WS_RESP
  } wstate_t;

  function automatic logic [31:0] f_merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] v;
    for (int b = 0; b < 4; b++)
      v[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    return v;
  endfunction

  function automatic logic [31:0] f_sext(
    input logic [ACC_W-1:0] v
  );
    return {{(32-ACC_W){v[ACC_W-1]}}, v};
  endfunction

  wstate_t             r_wstate;
  wstate_t             w_wstate_nxt;
  logic                w_do_write;
  logic                r_up;
  logic                r_aw_held;
  logic                r_w_held;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;

  logic [31:0]         r_tic;
  logic [31:0]         r_ctrl;
  logic [5:0]          r_prn;
  logic [PHASE_W-1:0]  r_carr;
  logic [PHASE_W-1:0]  r_code;
  logic [10:0]         r_slew;
  logic                r_slew_req;
  logic [31:0]         r_seq;
  logic [ACC_W-1:0]    r_acc [6];
  logic [ACC_W-1:0]    w_acc_in [6];

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic                w_wr_ok;
  logic                w_sreq_hit;
  logic [31:0]         w_old;
  logic [31:0]         w_mrg;
  logic [ADDR_W-1:0]   w_ra;
  logic [31:0]         w_rd_data;
  logic [1:0]          w_rd_resp;
  logic                w_unused;

  assign w_acc_in[0] = ie_in;
  assign w_acc_in[1] = qe_in;
  assign w_acc_in[2] = ip_in;
  assign w_acc_in[3] = qp_in;
  assign w_acc_in[4] = il_in;
  assign w_acc_in[5] = ql_in;

  assign w_unused = ^{s_axi.awaddr[31:ADDR_W], s_axi.awaddr[1:0],
                      s_axi.araddr[31:ADDR_W], s_axi.araddr[1:0]};

  assign s_axi.awready = r_up && (r_wstate == WS_ADDR) && !r_aw_held;
  assign s_axi.wready  = r_up && (r_wstate == WS_ADDR) && !r_w_held;
  assign s_axi.bvalid  = (r_wstate == WS_RESP);
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_up && !r_rvalid;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  assign w_aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_w_hs  = s_axi.wvalid && s_axi.wready;
  assign w_ar_hs = s_axi.arvalid && s_axi.arready;

  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_wstate <= WS_ADDR;
      r_up     <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_up     <= 1'b1;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_do_write   = 1'b0;
    unique case (r_wstate)
      WS_ADDR: begin
        if (r_aw_held && r_w_held) begin
          w_do_write   = 1'b1;
          w_wstate_nxt = WS_RESP;
        end
      end
      WS_RESP: begin
        if (s_axi.bready)
          w_wstate_nxt = WS_ADDR;
      end
      default: w_wstate_nxt = WS_ADDR;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_do_write) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= {s_axi.awaddr[ADDR_W-1:2], 2'b00};
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi.wdata;
        r_wstrb  <= s_axi.wstrb;
      end
    end
  end

  always_comb begin
    w_wr_ok    = 1'b0;
    w_sreq_hit = 1'b0;
    w_old      = '0;
    unique case (r_awaddr)
      A_TIC:  begin w_wr_ok = 1'b1; w_old = r_tic; end
      A_CTRL: begin w_wr_ok = 1'b1; w_old = r_ctrl; end
      A_PRN:  begin w_wr_ok = 1'b1; w_old = 32'(r_prn); end
      A_CARR: begin w_wr_ok = 1'b1; w_old = 32'(r_carr); end
      A_CODE: begin w_wr_ok = 1'b1; w_old = 32'(r_code); end
      A_SLEW: begin w_wr_ok = 1'b1; w_old = 32'(r_slew); end
      A_SREQ: begin w_wr_ok = 1'b1; w_sreq_hit = 1'b1; end
      default: ;
    endcase
  end

  assign w_mrg = f_merge(w_old, r_wdata, r_wstrb);

  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_tic      <= '0;
      r_ctrl     <= '0;
      r_prn      <= '0;
      r_carr     <= '0;
      r_code     <= '0;
      r_slew     <= '0;
      r_slew_req <= 1'b0;
      r_bresp    <= RESP_OK;
    end else begin
      r_slew_req <= w_do_write && w_sreq_hit &&
                    r_wstrb[0] && r_wdata[0];
      if (w_do_write) begin
        r_bresp <= w_wr_ok ? RESP_OK : RESP_ERR;
        unique case (r_awaddr)
          A_TIC:  r_tic  <= w_mrg;
          A_CTRL: r_ctrl <= w_mrg;
          A_PRN:  r_prn  <= w_mrg[5:0];
          A_CARR: r_carr <= w_mrg[PHASE_W-1:0];
          A_CODE: r_code <= w_mrg[PHASE_W-1:0];
          A_SLEW: r_slew <= w_mrg[10:0];
          default: ;
        endcase
      end
    end
  end

  assign w_ra = {s_axi.araddr[ADDR_W-1:2], 2'b00};

`ifdef GPS_CH_SNAP_LOCK_EN
  logic             r_locked;
  logic             r_pend;
  logic [ACC_W-1:0] r_pacc [6];
  logic [15:0]      r_lost;
  logic             w_lock;
  logic             w_unlock;

  assign w_lock   = w_ar_hs && (w_ra == A_SEQ);
  assign w_unlock = w_ar_hs && (w_ra == A_QL);

  // A locked dump parks in r_pacc; a newer one overwrites it as lost.
  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_locked <= 1'b0;
      r_pend   <= 1'b0;
      r_lost   <= '0;
      r_seq    <= '0;
      for (int i = 0; i < 6; i++) begin
        r_acc[i]  <= '0;
        r_pacc[i] <= '0;
      end
    end else begin
      if (w_lock)
        r_locked <= 1'b1;
      else if (w_unlock)
        r_locked <= 1'b0;
      if (r_locked) begin
        if (dump_in) begin
          r_pend <= 1'b1;
          r_pacc <= w_acc_in;
          if (r_pend && (r_lost != 16'hFFFF))
            r_lost <= r_lost + 16'd1;
        end
      end else if (dump_in) begin
        r_acc  <= w_acc_in;
        r_seq  <= r_seq + (r_pend ? 32'd2 : 32'd1);
        r_pend <= 1'b0;
      end else if (r_pend) begin
        r_acc  <= r_pacc;
        r_seq  <= r_seq + 32'd1;
        r_pend <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_seq <= '0;
      for (int i = 0; i < 6; i++)
        r_acc[i] <= '0;
    end else if (dump_in) begin
      r_acc <= w_acc_in;
      r_seq <= r_seq + 32'd1;
    end
  end
`endif

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OK;
    unique case (w_ra)
      A_TIC:  w_rd_data = r_tic;
      A_CTRL: w_rd_data = r_ctrl;
      A_PRN:  w_rd_data = 32'(r_prn);
      A_CARR: w_rd_data = 32'(r_carr);
      A_CODE: w_rd_data = 32'(r_code);
      A_SLEW: w_rd_data = 32'(r_slew);
      A_SREQ: w_rd_data = '0;
      A_SEQ:  w_rd_data = r_seq;
      A_IE:   w_rd_data = f_sext(r_acc[0]);
      A_QE:   w_rd_data = f_sext(r_acc[1]);
      A_IP:   w_rd_data = f_sext(r_acc[2]);
      A_QP:   w_rd_data = f_sext(r_acc[3]);
      A_IL:   w_rd_data = f_sext(r_acc[4]);
      A_QL:   w_rd_data = f_sext(r_acc[5]);
`ifdef GPS_CH_SNAP_LOCK_EN
      A_LOST: w_rd_data = {16'h0000, r_lost};
`endif
      default: w_rd_resp = RESP_ERR;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OK;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && s_axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign tic_cycles = r_tic;
  assign tic_en     = r_ctrl[0];
  assign prn        = r_prn;
  assign ch_en      = |r_prn;
  assign carr_incr  = r_carr;
  assign code_incr  = r_code;
  assign slew_hc    = r_slew;
  assign slew_req   = r_slew_req;

endmodule

// File: doc/gps_ch_axil_regs.md
Name: gps_ch_axil_regs

Overview:
- AXI4-Lite responder (slave) for one correlator channel, in the axi_clk domain.
- Holds the channel control registers: TIC, control, PRN, carrier/code NCO increments and code slew.
- Captures a coherent snapshot of the six E/P/L accumulators on each dump and serves it to the polling CPU/bench together with a dump sequence counter.
- Sits between the AXI interconnect and the sample-domain CDC stage, which presents dump_in and accumulators already synchronised to axi_clk.

Parameters:
ADDR_W, 12, significant AXI address bits (upper bits ignored)
ACC_W, 18, accumulator width, sign-extended to 32 on read
PHASE_W, 32, carrier/code NCO increment width

Ports:
axi_clk  in  1  clock
axi_rstn  in  1  synchronous active-low reset
s_axi_awaddr  in  32  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
dump_in  in  1  one-cycle dump strobe
ie_in, qe_in, ip_in, qp_in, il_in, ql_in  in  ACC_W each  signed accumulators, valid when dump_in=1
tic_cycles  out  32  PROG_TIC_CYCLES register
tic_en  out  1  CONTROL[0]
prn  out  6  PRN[5:0]
ch_en  out  1  1 when PRN register != 0
carr_incr  out  PHASE_W  carrier NCO increment
code_incr  out  PHASE_W  code NCO increment
slew_hc  out  11  code slew in half-chips
slew_req  out  1  one-cycle pulse

Behaviour:
- Address map, decoded on addr[ADDR_W-1:0] with bits[1:0] ignored:
  - 0x008 TIC RW
  - 0x00C CONTROL RW
  - 0x020 PRN RW
  - 0x024 CARR_INCR RW
  - 0x028 CODE_INCR RW
  - 0x02C SLEW_HC RW
  - 0x030 SLEW_REQ WO, reads 0
  - 0x100 DUMP_SEQ RO
  - 0x104 IE, 0x108 QE, 0x10C IP, 0x110 QP, 0x114 IL, 0x118 QL, all RO
- Reset, while axi_rstn=0 at a clock edge:
  - All registers 0.
  - awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, slew_req=0.
  - First cycle after reset: awready=wready=arready=1.
- Write channel:
  - AW and W are accepted independently, in either order or in the same cycle, and each is latched.
  - awready drops once AW is held; wready drops once W is held.
  - In the cycle after both are held, the write is performed with per-byte wstrb and bvalid=1.
  - bvalid holds until bready; awready and wready re-assert in the cycle after the B handshake.
  - One write is outstanding at a time.
- Write responses:
  - Write to a RO or unmapped address: no register change, bresp=SLVERR.
  - All other writes: bresp=OKAY.
- SLEW_REQ write with wdata[0]=1 and wstrb[0]=1: slew_req=1 for exactly one cycle, coincident with bvalid rising.
- Read channel:
  - arready = !rvalid.
  - On the AR handshake, rdata and rresp are registered and rvalid=1 the next cycle (1-cycle latency).
  - rdata is stable until rready; arready re-asserts the cycle after the R handshake.
- Read data:
  - Unmapped read: rdata=0, rresp=SLVERR.
  - Accumulators are sign-extended from ACC_W to 32 bits.
- Dump capture: on dump_in=1, all six accumulators are latched and DUMP_SEQ increments by 1 in the same edge. DUMP_SEQ wraps from 0xFFFFFFFF to 0.
- Simultaneous events:
  - A read sampled in the same cycle as a dump or a write returns the pre-update value.
  - A write and a dump do not interact.
- Reset asserted mid-transaction: the outstanding handshake is abandoned and no response is issued.

Optional Feature:
- Macro: GPS_CH_SNAP_LOCK_EN.
- With the macro defined:
  - Reading DUMP_SEQ locks the snapshot; reading QL unlocks it.
  - A dump_in arriving while locked is held in a one-deep pending buffer (accumulators plus the seq increment) and applied in the cycle after unlock.
  - A second dump arriving while a dump is already pending replaces the pending one and increments DUMP_LOST, a RO register at 0x11C that saturates at 0xFFFF.
- Without the macro: every dump overwrites the snapshot immediately, and 0x11C is unmapped (reads return 0 with SLVERR).

Test Plan:
1. Reset, then read each RW register -> 0, OKAY. Write CODE_INCR=0x0FFDFF7F, read back -> 0x0FFDFF7F. Write PRN=1 -> ch_en=1, prn=1.
2. AW presented 3 cycles before W, then W 2 cycles before AW, bready held low 5 cycles -> exactly one register update per write, bvalid held until bready, no second AW accepted meanwhile.
3. dump_in with ip_in=-5 (ACC_W=18) and qp_in=131071 -> IP reads 0xFFFFFFFB, QP reads 0x0001FFFF, DUMP_SEQ increments 0->1. Sixteen dumps -> DUMP_SEQ=16.
4. Write 1 to SLEW_REQ with SLEW_HC=100 -> single-cycle slew_req pulse, slew_hc=100. Write to 0x104 or read of 0x200 -> SLVERR, no state change.
5. Read of DUMP_SEQ issued in the same cycle as dump_in -> returns the old count; the next read returns old+1.
6. With GPS_CH_SNAP_LOCK_EN: read DUMP_SEQ, fire two dumps, read IE..QL -> values from the pre-lock dump, DUMP_LOST=1. After the QL read, the second dump is visible and DUMP_SEQ has advanced by 1.
